// File: rtl/usr_pkg.sv
// ============================================================================
// Module   : usr_pkg
// Brief    : Shared mode encoding and widths for the universal shift register.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package usr_pkg;

    localparam int USR_MODE_W = 3;

    typedef enum logic [USR_MODE_W-1:0] {
        USR_HOLD = 3'd0,
        USR_LOAD = 3'd1,
        USR_SHL  = 3'd2,
        USR_SHR  = 3'd3,
        USR_ROL  = 3'd4,
        USR_ROR  = 3'd5,
        USR_ASR  = 3'd6,
        USR_CLR  = 3'd7
    } usr_mode_e;

endpackage : usr_pkg

`default_nettype wire

// File: rtl/usr_next_val.sv
// ============================================================================
// Module   : usr_next_val
// Brief    : Combinational next-state logic for the register and serial-out bit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module usr_next_val
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  usr_mode_e        mode,
    input  logic [WIDTH-1:0] d,
    input  logic             ser_l,
    input  logic             ser_r,
    input  logic             ser_q,
    output logic [WIDTH-1:0] q_next,
    output logic             ser_next
);

    always_comb begin
        q_next   = q;
        ser_next = ser_q;
        case (mode)
            USR_HOLD: begin
                q_next   = q;
                ser_next = ser_q;
            end
            USR_LOAD: begin
                q_next   = d;
                ser_next = 1'b0;
            end
            USR_SHL: begin
                q_next   = {q[WIDTH-2:0], ser_r};
                ser_next = q[WIDTH-1];
            end
            USR_SHR: begin
                q_next   = {ser_l, q[WIDTH-1:1]};
                ser_next = q[0];
            end
            USR_ROL: begin
                q_next   = {q[WIDTH-2:0], q[WIDTH-1]};
                ser_next = q[WIDTH-1];
            end
            USR_ROR: begin
                q_next   = {q[0], q[WIDTH-1:1]};
                ser_next = q[0];
            end
            USR_ASR: begin
                // Sign bit is replicated, so negative values settle at all-ones
                q_next   = {q[WIDTH-1], q[WIDTH-1:1]};
                ser_next = q[0];
            end
            USR_CLR: begin
                q_next   = '0;
                ser_next = 1'b0;
            end
            default: begin
                q_next   = q;
                ser_next = ser_q;
            end
        endcase
    end

endmodule : usr_next_val

`default_nettype wire

// File: rtl/universal_shift_reg.sv
// ============================================================================
// Module   : universal_shift_reg
// Brief    : WIDTH-bit register with enable, load, clear, shifts and rotates.
//            Optional registered parity output enabled by macro USR_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module universal_shift_reg
    import usr_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  usr_mode_e        mode_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic             ser_l_i,
    input  logic             ser_r_i,
    output logic [WIDTH-1:0] q_o,
    output logic             ser_out_o,
`ifdef USR_PARITY_EN
    output logic             parity_o,
`endif
    output logic             zero_o
);

    generate
        if (WIDTH < 2) begin : g_width_chk
            $error("universal_shift_reg: WIDTH must be >= 2");
        end
    endgenerate

    localparam logic c_RESET_ZERO = (RESET_VAL == '0);

    logic [WIDTH-1:0] r_q;
    logic             r_ser;
    logic             r_zero;
    logic [WIDTH-1:0] w_q_next;
    logic             w_ser_next;

    usr_next_val #(
        .WIDTH (WIDTH)
    ) u_next_val (
        .q        (r_q),
        .mode     (mode_i),
        .d        (d_i),
        .ser_l    (ser_l_i),
        .ser_r    (ser_r_i),
        .ser_q    (r_ser),
        .q_next   (w_q_next),
        .ser_next (w_ser_next)
    );

    // Flags are derived from the next value so they line up with q_o
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q    <= RESET_VAL;
            r_ser  <= 1'b0;
            r_zero <= c_RESET_ZERO;
        end else if (en_i) begin
            r_q    <= w_q_next;
            r_ser  <= w_ser_next;
            r_zero <= (w_q_next == '0);
        end
    end

`ifdef USR_PARITY_EN
    logic r_par;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_par <= ^RESET_VAL;
        end else if (en_i) begin
            r_par <= ^w_q_next;
        end
    end

    assign parity_o = r_par;
`endif

    assign q_o       = r_q;
    assign ser_out_o = r_ser;
    assign zero_o    = r_zero;

endmodule : universal_shift_reg

`default_nettype wire

// File: tb/tb_universal_shift_reg.sv
// ============================================================================
// Module   : tb_universal_shift_reg
// Brief    : Directed, scoreboard-checked bench for universal_shift_reg.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_universal_shift_reg;
    import usr_pkg::*;

    localparam int         W   = 8;
    localparam logic [7:0] RV  = 8'hA5;

    typedef struct {
        logic [7:0] q;
        logic       ser;
        logic       zero;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       en_i;
    usr_mode_e  mode_i;
    logic [7:0] d_i;
    logic       ser_l_i;
    logic       ser_r_i;
    logic [7:0] q_o;
    logic       ser_out_o;
    logic       zero_o;
`ifdef USR_PARITY_EN
    logic       parity_o;
`endif

    int errors = 0;
    int checks = 0;

    exp_t       sb[$];
    logic [7:0] m_q;
    logic       m_ser;

    universal_shift_reg #(
        .WIDTH     (W),
        .RESET_VAL (RV)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en_i      (en_i),
        .mode_i    (mode_i),
        .d_i       (d_i),
        .ser_l_i   (ser_l_i),
        .ser_r_i   (ser_r_i),
        .q_o       (q_o),
        .ser_out_o (ser_out_o),
`ifdef USR_PARITY_EN
        .parity_o  (parity_o),
`endif
        .zero_o    (zero_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input exp_t e);
        check({tag, ".q"},    q_o,               e.q);
        check({tag, ".ser"},  {7'b0, ser_out_o}, {7'b0, e.ser});
        check({tag, ".zero"}, {7'b0, zero_o},    {7'b0, e.zero});
`ifdef USR_PARITY_EN
        check({tag, ".par"},  {7'b0, parity_o},  {7'b0, ^e.q});
`endif
    endtask

    // Reference behaviour, written with shift operators rather than slicing
    task automatic model(input usr_mode_e m, input logic [7:0] d, input logic sl, input logic sr);
        case (m)
            USR_HOLD: ;
            USR_LOAD: begin m_q = d; m_ser = 1'b0; end
            USR_SHL:  begin m_ser = m_q[7]; m_q = (m_q << 1) | {7'b0, sr}; end
            USR_SHR:  begin m_ser = m_q[0]; m_q = (m_q >> 1) | {sl, 7'b0}; end
            USR_ROL:  begin m_ser = m_q[7]; m_q = (m_q << 1) | (m_q >> 7); end
            USR_ROR:  begin m_ser = m_q[0]; m_q = (m_q >> 1) | (m_q << 7); end
            USR_ASR:  begin m_ser = m_q[0]; m_q = 8'($signed(m_q) >>> 1); end
            USR_CLR:  begin m_q = 8'h00; m_ser = 1'b0; end
            default: ;
        endcase
    endtask

    task automatic step(input string tag, input logic en, input usr_mode_e m,
                        input logic [7:0] d, input logic sl, input logic sr);
        exp_t e;
        @(negedge clk);
        en_i = en; mode_i = m; d_i = d; ser_l_i = sl; ser_r_i = sr;
        if (en) model(m, d, sl, sr);
        e.q = m_q; e.ser = m_ser; e.zero = (m_q == 8'h00);
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++; errors++;
            $error("FAIL %s.sb: observed=empty expected=entry", tag);
        end else begin
            e = sb.pop_front();
            check_outputs(tag, e);
        end
    endtask

    initial begin
        exp_t rst_e;
        logic [7:0] rol_bits;

        rst_e.q = RV; rst_e.ser = 1'b0; rst_e.zero = 1'b0;

        // Reset asserted before any clock edge
        reset = 1'b1; en_i = 1'b0; mode_i = USR_HOLD; d_i = 8'h00;
        ser_l_i = 1'b0; ser_r_i = 1'b0;
        #2 reset = 1'b0;
        #1 check_outputs("reset", rst_e);
        m_q = RV; m_ser = 1'b0;
        #8 reset = 1'b1;

        // Load then hold with enable low
        step("load3c", 1'b1, USR_LOAD, 8'h3C, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++)
            step("hold_en0", 1'b0, USR_SHL, 8'hFF, 1'b1, 1'b1);

        // Single shifts from 8'h81
        step("load81a", 1'b1, USR_LOAD, 8'h81, 1'b0, 1'b0);
        step("shl",     1'b1, USR_SHL,  8'h00, 1'b0, 1'b1);
        check("shl_const", q_o, 8'h03);
        step("hold_mode", 1'b1, USR_HOLD, 8'hFF, 1'b1, 1'b1);
        step("load81b", 1'b1, USR_LOAD, 8'h81, 1'b0, 1'b0);
        step("shr",     1'b1, USR_SHR,  8'h00, 1'b0, 1'b1);
        check("shr_const", q_o, 8'h40);

        // Eight rotates return the original; ser_out collects bits MSB-first
        step("load96", 1'b1, USR_LOAD, 8'h96, 1'b0, 1'b0);
        rol_bits = 8'h00;
        for (int i = 0; i < 8; i++) begin
            step("rol", 1'b1, USR_ROL, 8'h00, 1'b1, 1'b1);
            rol_bits = {rol_bits[6:0], ser_out_o};
        end
        check("rol_wrap", q_o, 8'h96);
        check("rol_serseq", rol_bits, 8'h96);
        for (int i = 0; i < 3; i++)
            step("ror", 1'b1, USR_ROR, 8'h00, 1'b1, 1'b0);

        // Arithmetic shift saturates at all-ones, then clear
        step("load80", 1'b1, USR_LOAD, 8'h80, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++)
            step("asr", 1'b1, USR_ASR, 8'h00, 1'b0, 1'b0);
        check("asr_sat", q_o, 8'hFF);
        step("asr_more", 1'b1, USR_ASR, 8'h00, 1'b0, 1'b0);
        step("clr", 1'b1, USR_CLR, 8'h5A, 1'b1, 1'b1);
        check("clr_zero", {7'b0, zero_o}, 8'h01);

        // Shifting zeros in drains the register after WIDTH shifts
        step("load_ff", 1'b1, USR_LOAD, 8'hFF, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++)
            step("shr_drain", 1'b1, USR_SHR, 8'h00, 1'b0, 1'b1);
        check("drain_zero", {7'b0, zero_o}, 8'h01);

        // Reset pulse between edges during a shift run
        step("load01", 1'b1, USR_LOAD, 8'h01, 1'b0, 1'b0);
        step("shl_run", 1'b1, USR_SHL, 8'h00, 1'b0, 1'b1);
        step("shl_run", 1'b1, USR_SHL, 8'h00, 1'b0, 1'b0);
        #1 reset = 1'b0;
        #1 check_outputs("reset_mid", rst_e);
        m_q = RV; m_ser = 1'b0;
        #1 reset = 1'b1;
        for (int i = 0; i < 3; i++)
            step("shl_resume", 1'b1, USR_SHL, 8'h00, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_universal_shift_reg

`default_nettype wire

// File: doc/universal_shift_reg.md
Name: universal_shift_reg

Overview:
- Parametrised successor to the team's single-bit D flip-flop primitives: a WIDTH-bit register bank with clock enable, parallel load, synchronous clear, and logical, rotate and arithmetic shifts.
- Used as the general-purpose storage, serialiser and deserialiser element in datapaths.
- Provides a registered serial-out bit and a registered zero flag.

Parameters:
- WIDTH, 8, register width in bits; must be >= 2 (elaboration-time assertion).
- RESET_VAL, '0, WIDTH-bit value loaded into q_o on asynchronous reset.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- en_i  input  1  clock enable; when 0, all state holds.
- mode_i  input  3  operation select (usr_mode_e).
- d_i  input  WIDTH  parallel load data.
- ser_l_i  input  1  serial-in bit entering at MSB on SHR.
- ser_r_i  input  1  serial-in bit entering at LSB on SHL.
- q_o  output  WIDTH  register contents.
- ser_out_o  output  1  bit shifted or rotated out by the last shift/rotate.
- zero_o  output  1  registered flag, equal to (q_o == 0).

Behaviour:
- Reset, immediate and independent of clk:
  - q_o = RESET_VAL.
  - ser_out_o = 0.
  - zero_o = (RESET_VAL == 0).
- Reset asserted mid-operation overrides everything. The first update after deassertion occurs on the first rising edge where reset = 1.
- All updates occur on the rising edge of clk. Latency is 1 cycle from inputs to q_o, ser_out_o and zero_o.
- en_i = 0: q_o, ser_out_o and zero_o hold, whatever mode_i is.
- en_i = 1, per mode_i (q is the current q_o):
  - HOLD (0): q holds; ser_out_o holds.
  - LOAD (1): q <= d_i; ser_out_o <= 0.
  - SHL (2): q <= {q[W-2:0], ser_r_i}; ser_out_o <= q[W-1].
  - SHR (3): q <= {ser_l_i, q[W-1:1]}; ser_out_o <= q[0].
  - ROL (4): q <= {q[W-2:0], q[W-1]}; ser_out_o <= q[W-1].
  - ROR (5): q <= {q[0], q[W-1:1]}; ser_out_o <= q[0].
  - ASR (6): q <= {q[W-1], q[W-1:1]} (sign preserved); ser_out_o <= q[0].
  - CLR (7): q <= 0; ser_out_o <= 0.
- All 8 encodings are legal, so there are no undefined modes.
- Serial inputs are ignored except in SHL and SHR.
- zero_o is computed from the next value of q and registered alongside it, so zero_o always matches the current q_o in the same cycle.
- Wrap-around:
  - ROL/ROR lose no bits; WIDTH consecutive rotates return the original value.
  - SHL/SHR with a constant serial input of 0 reach zero after WIDTH shifts.
  - ASR of a negative value saturates at all-ones.
- No X-propagation into q_o from unused inputs.

Optional Feature:
- Macro: USR_PARITY_EN.
- Defined:
  - Adds output port parity_o (1 bit) = ^q_o, registered with the next q value (same-cycle consistent with q_o).
  - Reset value of parity_o is ^RESET_VAL.
  - parity_o holds when en_i = 0.
- Undefined: parity_o port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package usr_pkg contains:
  - typedef enum logic [2:0] usr_mode_e {USR_HOLD, USR_LOAD, USR_SHL, USR_SHR, USR_ROL, USR_ROR, USR_ASR, USR_CLR}, with encodings 0..7 as listed above.
  - localparam USR_MODE_W = 3.
- Sub-module usr_next_val: purely combinational. Takes q, mode, d_i and the serial inputs; produces the next q and next ser_out. The top level holds all flops, the enable and the reset.

Test Plan:
- Reset: WIDTH=8, RESET_VAL=8'hA5; assert reset low between clock edges -> q_o=8'hA5, ser_out_o=0 and zero_o=0 immediately, with no clock edge needed.
- Load then hold: LOAD d_i=8'h3C, then en_i=0 with mode_i=SHL for 3 cycles -> q_o stays 8'h3C, ser_out_o stays 0.
- Shift left: from 8'h81, SHL with ser_r_i=1 -> q_o=8'h03, ser_out_o=1. SHR from 8'h81 with ser_l_i=0 -> q_o=8'h40, ser_out_o=1.
- Rotate: 8 ROL cycles from 8'h96 -> q_o back to 8'h96. The ser_out_o sequence equals the bits of 8'h96 MSB-first.
- Arithmetic shift: ASR from 8'h80 repeated 7 times -> q_o=8'hFF, zero_o=0 throughout. Then CLR -> q_o=0 and zero_o=1 on the same edge.
- Reset mid-shift: during a run of SHL operations, pulse reset low for less than one clock period -> q_o returns to RESET_VAL immediately. Shifting resumes on the first edge after release. With USR_PARITY_EN defined, parity_o equals ^q_o on every cycle.
